// File: rtl/id_ex_fwd_stage.sv
// ID/EX pipeline register with load-use hazard detection, one-bubble stall
// insertion, EX operand-mux forwarding selects and a saturating stall counter.
// Select encoding: 00 = register data, 01 = EX/MEM result,
//                  10 = MEM/WB write-back data, 11 = ex_imm.
module id_ex_fwd_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic [REG_W-1:0]  id_rd,
  input  logic              id_uses_rt,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_alu_src,
  input  logic              flush_i,
  input  logic              exmem_reg_write,
  input  logic [REG_W-1:0]  exmem_rd,
  input  logic              memwb_reg_write,
  input  logic [REG_W-1:0]  memwb_rd,
  output logic              stall_o,
  output logic              ex_valid,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_alu_src,
  output logic [REG_W-1:0]  ex_rs,
  output logic [REG_W-1:0]  ex_rt,
  output logic [REG_W-1:0]  ex_rd,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic [1:0]        fwd_st_sel,
  output logic [CNT_W-1:0]  stall_count
);

  localparam logic [REG_W-1:0]  REG_ZERO  = {REG_W{1'b0}};
  localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  logic              ex_valid_q,     ex_valid_d;
  logic              ex_reg_write_q, ex_reg_write_d;
  logic              ex_mem_read_q,  ex_mem_read_d;
  logic              ex_mem_write_q, ex_mem_write_d;
  logic              ex_alu_src_q,   ex_alu_src_d;
  logic [REG_W-1:0]  ex_rs_q,        ex_rs_d;
  logic [REG_W-1:0]  ex_rt_q,        ex_rt_d;
  logic [REG_W-1:0]  ex_rd_q,        ex_rd_d;
  logic [DATA_W-1:0] ex_rs_data_q,   ex_rs_data_d;
  logic [DATA_W-1:0] ex_rt_data_q,   ex_rt_data_d;
  logic [DATA_W-1:0] ex_imm_q,       ex_imm_d;
  logic [CNT_W-1:0]  stall_count_q,  stall_count_d;

  logic       haz_s;
  logic       stall_s;
  logic [1:0] fwd_a_s;
  logic [1:0] fwd_b_s;
  logic [1:0] fwd_st_s;

  // Newest producer wins: EX/MEM is checked before MEM/WB; $0 never forwards.
  function automatic logic [1:0] fwd_code(
    input logic [REG_W-1:0] r,
    input logic             mem_we,
    input logic [REG_W-1:0] mem_rd,
    input logic             wb_we,
    input logic [REG_W-1:0] wb_rd
  );
    logic [1:0] code;
    if (mem_we && (mem_rd != REG_ZERO) && (mem_rd == r)) begin
      code = 2'b01;
    end else if (wb_we && (wb_rd != REG_ZERO) && (wb_rd == r)) begin
      code = 2'b10;
    end else begin
      code = 2'b00;
    end
    return code;
  endfunction

  // Load-use detection: a load in EX whose result the ID instruction needs now.
  always_comb begin
    haz_s = 1'b0;
    if (ex_valid_q && ex_mem_read_q && (ex_rd_q != REG_ZERO) && id_valid) begin
      haz_s = (ex_rd_q == id_rs) || (id_uses_rt && (ex_rd_q == id_rt));
    end else begin
      haz_s = 1'b0;
    end
    // A flush kills the dependent instruction anyway, so no stall is needed.
    stall_s = haz_s && !flush_i;
  end

  // Next ID/EX contents: bubble on flush or stall, otherwise capture decode.
  always_comb begin
    ex_valid_d     = 1'b0;
    ex_reg_write_d = 1'b0;
    ex_mem_read_d  = 1'b0;
    ex_mem_write_d = 1'b0;
    ex_alu_src_d   = 1'b0;
    ex_rs_d        = REG_ZERO;
    ex_rt_d        = REG_ZERO;
    ex_rd_d        = REG_ZERO;
    ex_rs_data_d   = DATA_ZERO;
    ex_rt_data_d   = DATA_ZERO;
    ex_imm_d       = DATA_ZERO;
    if (flush_i || stall_s) begin
      ex_valid_d = 1'b0;
    end else begin
      ex_valid_d     = id_valid;
      ex_reg_write_d = id_valid && id_reg_write;
      ex_mem_read_d  = id_valid && id_mem_read;
      ex_mem_write_d = id_valid && id_mem_write;
      ex_alu_src_d   = id_valid && id_alu_src;
      ex_rs_d        = id_rs;
      ex_rt_d        = id_rt;
      ex_rd_d        = id_rd;
      ex_rs_data_d   = id_rs_data;
      ex_rt_data_d   = id_rt_data;
      ex_imm_d       = id_imm;
    end
  end

  // Stall counter sticks at all-ones instead of wrapping.
  always_comb begin
    stall_count_d = stall_count_q;
    if (stall_s && (stall_count_q != CNT_MAX)) begin
      stall_count_d = stall_count_q + CNT_ONE;
    end else begin
      stall_count_d = stall_count_q;
    end
  end

  // Operand-mux selects from the registered sources and live downstream stages.
  always_comb begin
    fwd_a_s  = 2'b00;
    fwd_b_s  = 2'b00;
    fwd_st_s = 2'b00;
    if (ex_valid_q) begin
      fwd_a_s  = fwd_code(ex_rs_q, exmem_reg_write, exmem_rd, memwb_reg_write, memwb_rd);
      fwd_st_s = fwd_code(ex_rt_q, exmem_reg_write, exmem_rd, memwb_reg_write, memwb_rd);
      fwd_b_s  = ex_alu_src_q ? 2'b11 : fwd_st_s;
    end else begin
      fwd_a_s  = 2'b00;
      fwd_b_s  = 2'b00;
      fwd_st_s = 2'b00;
    end
  end

  // Pipeline register and counter state with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_valid_q     <= 1'b0;
      ex_reg_write_q <= 1'b0;
      ex_mem_read_q  <= 1'b0;
      ex_mem_write_q <= 1'b0;
      ex_alu_src_q   <= 1'b0;
      ex_rs_q        <= REG_ZERO;
      ex_rt_q        <= REG_ZERO;
      ex_rd_q        <= REG_ZERO;
      ex_rs_data_q   <= DATA_ZERO;
      ex_rt_data_q   <= DATA_ZERO;
      ex_imm_q       <= DATA_ZERO;
      stall_count_q  <= {CNT_W{1'b0}};
    end else begin
      ex_valid_q     <= ex_valid_d;
      ex_reg_write_q <= ex_reg_write_d;
      ex_mem_read_q  <= ex_mem_read_d;
      ex_mem_write_q <= ex_mem_write_d;
      ex_alu_src_q   <= ex_alu_src_d;
      ex_rs_q        <= ex_rs_d;
      ex_rt_q        <= ex_rt_d;
      ex_rd_q        <= ex_rd_d;
      ex_rs_data_q   <= ex_rs_data_d;
      ex_rt_data_q   <= ex_rt_data_d;
      ex_imm_q       <= ex_imm_d;
      stall_count_q  <= stall_count_d;
    end
  end

  assign stall_o      = stall_s;
  assign ex_valid     = ex_valid_q;
  assign ex_reg_write = ex_reg_write_q;
  assign ex_mem_read  = ex_mem_read_q;
  assign ex_mem_write = ex_mem_write_q;
  assign ex_alu_src   = ex_alu_src_q;
  assign ex_rs        = ex_rs_q;
  assign ex_rt        = ex_rt_q;
  assign ex_rd        = ex_rd_q;
  assign ex_rs_data   = ex_rs_data_q;
  assign ex_rt_data   = ex_rt_data_q;
  assign ex_imm       = ex_imm_q;
  assign fwd_a_sel    = fwd_a_s;
  assign fwd_b_sel    = fwd_b_s;
  assign fwd_st_sel   = fwd_st_s;
  assign stall_count  = stall_count_q;

endmodule

// File: tb/tb_id_ex_fwd_stage.sv
// Directed bench for id_ex_fwd_stage: a default-width instance plus a
// CNT_W=4 instance (same stimulus) used for the counter saturation case.
module tb_id_ex_fwd_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        id_uses_rt;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic        id_reg_write, id_mem_read, id_mem_write, id_alu_src;
  logic        flush_i;
  logic        exmem_reg_write;
  logic [4:0]  exmem_rd;
  logic        memwb_reg_write;
  logic [4:0]  memwb_rd;

  logic        stall_o, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic [31:0] ex_rs_data, ex_rt_data, ex_imm;
  logic [1:0]  fwd_a_sel, fwd_b_sel, fwd_st_sel;
  logic [15:0] stall_count;

  logic        s_stall_o, s_ex_valid, s_ex_reg_write, s_ex_mem_read, s_ex_mem_write, s_ex_alu_src;
  logic [4:0]  s_ex_rs, s_ex_rt, s_ex_rd;
  logic [31:0] s_ex_rs_data, s_ex_rt_data, s_ex_imm;
  logic [1:0]  s_fwd_a_sel, s_fwd_b_sel, s_fwd_st_sel;
  logic [3:0]  s_stall_count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  id_ex_fwd_stage dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_uses_rt(id_uses_rt), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_alu_src(id_alu_src), .flush_i(flush_i), .exmem_reg_write(exmem_reg_write),
    .exmem_rd(exmem_rd), .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd),
    .stall_o(stall_o), .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_alu_src(ex_alu_src), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm), .fwd_a_sel(fwd_a_sel),
    .fwd_b_sel(fwd_b_sel), .fwd_st_sel(fwd_st_sel), .stall_count(stall_count)
  );

  id_ex_fwd_stage #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_uses_rt(id_uses_rt), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_alu_src(id_alu_src), .flush_i(flush_i), .exmem_reg_write(exmem_reg_write),
    .exmem_rd(exmem_rd), .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd),
    .stall_o(s_stall_o), .ex_valid(s_ex_valid), .ex_reg_write(s_ex_reg_write),
    .ex_mem_read(s_ex_mem_read), .ex_mem_write(s_ex_mem_write), .ex_alu_src(s_ex_alu_src),
    .ex_rs(s_ex_rs), .ex_rt(s_ex_rt), .ex_rd(s_ex_rd), .ex_rs_data(s_ex_rs_data),
    .ex_rt_data(s_ex_rt_data), .ex_imm(s_ex_imm), .fwd_a_sel(s_fwd_a_sel),
    .fwd_b_sel(s_fwd_b_sel), .fwd_st_sel(s_fwd_st_sel), .stall_count(s_stall_count)
  );

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic id_set(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic urt, input logic rw, input logic mr,
                        input logic mw, input logic as, input logic [31:0] rsd,
                        input logic [31:0] rtd, input logic [31:0] imm);
    id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd; id_uses_rt = urt;
    id_reg_write = rw; id_mem_read = mr; id_mem_write = mw; id_alu_src = as;
    id_rs_data = rsd; id_rt_data = rtd; id_imm = imm;
  endtask

  task automatic fwd_set(input logic mwe, input logic [4:0] mrd, input logic wwe, input logic [4:0] wrd);
    exmem_reg_write = mwe; exmem_rd = mrd; memwb_reg_write = wwe; memwb_rd = wrd;
  endtask

  // lw $8, 0($1)
  task automatic id_lw8();
    id_set(1'b1, 5'd1, 5'd0, 5'd8, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0, 32'h4);
  endtask

  // add $9, $8, $10
  task automatic id_add_dep();
    id_set(1'b1, 5'd8, 5'd10, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h11, 32'h22, 32'h0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      id_set(1'b1, 5'($urandom), 5'($urandom), 5'($urandom), 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
             $urandom, $urandom, $urandom);
      fwd_set(1'b1, 5'($urandom), 1'b1, 5'($urandom));
      tick();
    end
    tests++; if (ex_valid !== 1'b0) begin fails++; $display("FAIL reset_ex_valid got %0h want 0", ex_valid); end
    tests++; if ({ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src} !== 4'b0000) begin fails++; $display("FAIL reset_ctrl got %b want 0000", {ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src}); end
    tests++; if ({ex_rs, ex_rt, ex_rd} !== 15'd0) begin fails++; $display("FAIL reset_regs got %0h want 0", {ex_rs, ex_rt, ex_rd}); end
    tests++; if ({ex_rs_data, ex_rt_data, ex_imm} !== 96'd0) begin fails++; $display("FAIL reset_data got %0h want 0", {ex_rs_data, ex_rt_data, ex_imm}); end
    tests++; if ({fwd_a_sel, fwd_b_sel, fwd_st_sel} !== 6'b000000) begin fails++; $display("FAIL reset_sel got %b want 000000", {fwd_a_sel, fwd_b_sel, fwd_st_sel}); end
    tests++; if (stall_count !== 16'd0) begin fails++; $display("FAIL reset_count got %0d want 0", stall_count); end
    tests++; if (stall_o !== 1'b0) begin fails++; $display("FAIL reset_stall got %0h want 0", stall_o); end
    rst_n = 1'b1;
    flush_i = 1'b0;
    id_set(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    fwd_set(1'b0, 5'd0, 1'b0, 5'd0);
    tick();
  endtask

  task automatic test_load_use();
    id_lw8();
    #1;
    tests++; if (stall_o !== 1'b0) begin fails++; $display("FAIL lu_no_stall_first got %0h want 0", stall_o); end
    tick();
    tests++; if ({ex_valid, ex_mem_read, ex_rd} !== {1'b1, 1'b1, 5'd8}) begin fails++; $display("FAIL lu_lw_in_ex got %0h want %0h", {ex_valid, ex_mem_read, ex_rd}, {1'b1, 1'b1, 5'd8}); end
    id_add_dep();
    #1;
    tests++; if (stall_o !== 1'b1) begin fails++; $display("FAIL lu_stall got %0h want 1", stall_o); end
    tick();
    tests++; if ({ex_valid, ex_reg_write, ex_rs, ex_rd} !== 12'd0) begin fails++; $display("FAIL lu_bubble got %0h want 0", {ex_valid, ex_reg_write, ex_rs, ex_rd}); end
    tests++; if (stall_count !== 16'd1) begin fails++; $display("FAIL lu_count got %0d want 1", stall_count); end
    tests++; if (stall_o !== 1'b0) begin fails++; $display("FAIL lu_stall_drops got %0h want 0", stall_o); end
    fwd_set(1'b0, 5'd0, 1'b1, 5'd8);
    tick();
    tests++; if ({ex_valid, ex_rs, ex_rt, ex_rd} !== {1'b1, 5'd8, 5'd10, 5'd9}) begin fails++; $display("FAIL lu_add_in_ex got %0h want %0h", {ex_valid, ex_rs, ex_rt, ex_rd}, {1'b1, 5'd8, 5'd10, 5'd9}); end
    tests++; if (fwd_a_sel !== 2'b10) begin fails++; $display("FAIL lu_fwd_a got %b want 10", fwd_a_sel); end
    tests++; if (fwd_b_sel !== 2'b00) begin fails++; $display("FAIL lu_fwd_b got %b want 00", fwd_b_sel); end
    tests++; if (ex_rs_data !== 32'h11) begin fails++; $display("FAIL lu_rs_data got %0h want 11", ex_rs_data); end
    tests++; if (stall_count !== 16'd1) begin fails++; $display("FAIL lu_count_hold got %0d want 1", stall_count); end
  endtask

  task automatic test_double_forward();
    fwd_set(1'b0, 5'd0, 1'b0, 5'd0);
    id_set(1'b1, 5'd5, 5'd6, 5'd11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h55, 32'h66, 32'h0);
    tick();
    fwd_set(1'b1, 5'd5, 1'b1, 5'd5);
    #1;
    tests++; if (fwd_a_sel !== 2'b01) begin fails++; $display("FAIL df_both got %b want 01", fwd_a_sel); end
    tests++; if (fwd_b_sel !== 2'b00) begin fails++; $display("FAIL df_b_nomatch got %b want 00", fwd_b_sel); end
    exmem_rd = 5'd0;
    #1;
    tests++; if (fwd_a_sel !== 2'b10) begin fails++; $display("FAIL df_wb_only got %b want 10", fwd_a_sel); end
    memwb_rd = 5'd0;
    #1;
    tests++; if (fwd_a_sel !== 2'b00) begin fails++; $display("FAIL df_none got %b want 00", fwd_a_sel); end
    fwd_set(1'b0, 5'd5, 1'b0, 5'd5);
    #1;
    tests++; if (fwd_a_sel !== 2'b00) begin fails++; $display("FAIL df_we_off got %b want 00", fwd_a_sel); end
    fwd_set(1'b0, 5'd0, 1'b0, 5'd0);
  endtask

  task automatic test_imm_store();
    // sw $7, 16($2)
    id_set(1'b1, 5'd2, 5'd7, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h2, 32'h7, 32'h10);
    tick();
    fwd_set(1'b1, 5'd7, 1'b0, 5'd0);
    #1;
    tests++; if (fwd_b_sel !== 2'b11) begin fails++; $display("FAIL st_b_imm got %b want 11", fwd_b_sel); end
    tests++; if (fwd_st_sel !== 2'b01) begin fails++; $display("FAIL st_mem got %b want 01", fwd_st_sel); end
    tests++; if (fwd_a_sel !== 2'b00) begin fails++; $display("FAIL st_a got %b want 00", fwd_a_sel); end
    tests++; if ({ex_mem_write, ex_alu_src, ex_imm} !== {2'b11, 32'h10}) begin fails++; $display("FAIL st_fields got %0h want %0h", {ex_mem_write, ex_alu_src, ex_imm}, {2'b11, 32'h10}); end
    fwd_set(1'b1, 5'd7, 1'b1, 5'd7);
    #1;
    tests++; if (fwd_st_sel !== 2'b01) begin fails++; $display("FAIL st_priority got %b want 01", fwd_st_sel); end
    fwd_set(1'b0, 5'd7, 1'b1, 5'd7);
    #1;
    tests++; if (fwd_st_sel !== 2'b10) begin fails++; $display("FAIL st_wb got %b want 10", fwd_st_sel); end
    fwd_set(1'b0, 5'd0, 1'b0, 5'd0);
  endtask

  task automatic test_rt_hazard();
    id_lw8();
    tick();
    id_set(1'b1, 5'd3, 5'd8, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    #1;
    tests++; if (stall_o !== 1'b0) begin fails++; $display("FAIL rt_unused got %0h want 0", stall_o); end
    id_uses_rt = 1'b1;
    #1;
    tests++; if (stall_o !== 1'b1) begin fails++; $display("FAIL rt_used got %0h want 1", stall_o); end
    id_valid = 1'b0;
    #1;
    tests++; if (stall_o !== 1'b0) begin fails++; $display("FAIL rt_id_invalid got %0h want 0", stall_o); end
    tick();
    tests++; if ({ex_valid, ex_reg_write} !== 2'b00) begin fails++; $display("FAIL invalid_ctrl got %b want 00", {ex_valid, ex_reg_write}); end
    fwd_set(1'b1, 5'd3, 1'b0, 5'd0);
    #1;
    tests++; if (fwd_a_sel !== 2'b00) begin fails++; $display("FAIL invalid_sel got %b want 00", fwd_a_sel); end
    fwd_set(1'b0, 5'd0, 1'b0, 5'd0);
  endtask

  task automatic test_reg_zero();
    // lw $0 then a reader of $0: no hazard, no forwarding.
    id_set(1'b1, 5'd1, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0);
    tick();
    id_set(1'b1, 5'd0, 5'd0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    #1;
    tests++; if (stall_o !== 1'b0) begin fails++; $display("FAIL zero_no_stall got %0h want 0", stall_o); end
    tick();
    fwd_set(1'b1, 5'd0, 1'b1, 5'd0);
    #1;
    tests++; if ({fwd_a_sel, fwd_st_sel} !== 4'b0000) begin fails++; $display("FAIL zero_no_fwd got %b want 0000", {fwd_a_sel, fwd_st_sel}); end
    fwd_set(1'b0, 5'd0, 1'b0, 5'd0);
  endtask

  task automatic test_flush_hazard();
    id_lw8();
    tick();
    id_add_dep();
    flush_i = 1'b1;
    #1;
    tests++; if (stall_o !== 1'b0) begin fails++; $display("FAIL flush_stall got %0h want 0", stall_o); end
    tick();
    flush_i = 1'b0;
    tests++; if ({ex_valid, ex_reg_write, ex_rs, ex_rt, ex_rd, ex_rs_data} !== 49'd0) begin fails++; $display("FAIL flush_bubble got %0h want 0", {ex_valid, ex_reg_write, ex_rs, ex_rt, ex_rd, ex_rs_data}); end
    tests++; if (stall_count !== 16'd1) begin fails++; $display("FAIL flush_count got %0d want 1", stall_count); end
  endtask

  task automatic test_reset_mid_stall();
    id_lw8();
    tick();
    id_add_dep();
    #1;
    tests++; if (stall_o !== 1'b1) begin fails++; $display("FAIL rms_stall got %0h want 1", stall_o); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tests++; if ({ex_valid, stall_count, s_stall_count} !== 21'd0) begin fails++; $display("FAIL rms_cleared got %0h want 0", {ex_valid, stall_count, s_stall_count}); end
    tests++; if (stall_o !== 1'b0) begin fails++; $display("FAIL rms_stall_drop got %0h want 0", stall_o); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 20; i++) begin
      id_lw8();
      tick();
      id_add_dep();
      #1;
      tests++; if (s_stall_o !== 1'b1) begin fails++; $display("FAIL sat_stall_%0d got %0h want 1", i, s_stall_o); end
      tick();
      if (i == 13) begin
        tests++; if (s_stall_count !== 4'd14) begin fails++; $display("FAIL sat_mid got %0d want 14", s_stall_count); end
      end
    end
    tests++; if (s_stall_count !== 4'hF) begin fails++; $display("FAIL sat_stick got %0h want f", s_stall_count); end
    tests++; if (stall_count !== 16'd20) begin fails++; $display("FAIL sat_wide got %0d want 20", stall_count); end
  endtask

  initial begin
    rst_n = 1'b0;
    flush_i = 1'b0;
    id_set(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    fwd_set(1'b0, 5'd0, 1'b0, 5'd0);
    test_reset();
    test_load_use();
    test_double_forward();
    test_imm_store();
    test_rt_hazard();
    test_reg_zero();
    test_flush_hazard();
    test_reset_mid_stall();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/id_ex_fwd_stage.md
Name: id_ex_fwd_stage

Overview:
- ID/EX pipeline register for the pipelined CPU, directly upstream of the EX-stage 4:1 operand multiplexers.
- Latches the decoded instruction fields and detects load-use hazards, inserting one bubble per hazard.
- Generates the 2-bit operand-select codes consumed by the EX operand muxes.
- Keeps a saturating count of stall cycles for performance monitoring.

Parameters:
- DATA_W, 32, width of operand/immediate datapath
- REG_W, 5, register-number width
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  synchronous active-low reset
- id_valid  in  1  ID stage holds a real instruction
- id_rs, id_rt, id_rd  in  REG_W each  source/dest register numbers from decode
- id_uses_rt  in  1  instruction reads rt (R-type, store, branch)
- id_rs_data, id_rt_data  in  DATA_W each  register-file read data
- id_imm  in  DATA_W  sign/zero-extended immediate
- id_reg_write, id_mem_read, id_mem_write, id_alu_src  in  1 each  decode controls
- flush_i  in  1  kill the instruction entering EX (taken branch/jump)
- exmem_reg_write  in  1  EX/MEM instruction writes the register file
- exmem_rd  in  REG_W  EX/MEM destination
- memwb_reg_write  in  1  MEM/WB instruction writes the register file
- memwb_rd  in  REG_W  MEM/WB destination
- stall_o  out  1  hold PC and IF/ID this cycle (combinational)
- ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src  out  1 each  registered controls
- ex_rs, ex_rt, ex_rd  out  REG_W each  registered register numbers
- ex_rs_data, ex_rt_data, ex_imm  out  DATA_W each  registered operands
- fwd_a_sel  out  2  operand A mux select
- fwd_b_sel  out  2  operand B mux select
- fwd_st_sel  out  2  store-data mux select
- stall_count  out  CNT_W  saturating count of cycles with stall_o=1

Behaviour:
- One clock (clk). Reset is synchronous, active-low (rst_n). On any rising edge with rst_n=0:
  - all ex_* outputs, including ex_valid, are cleared to 0
  - stall_count is cleared to 0
  - fwd selects read 00 because they derive from the cleared registers
- Hazard (combinational):
  - haz = ex_valid & ex_mem_read & ex_rd!=0 & (ex_rd==id_rs | (id_uses_rt & ex_rd==id_rt)) & id_valid
  - stall_o = haz & ~flush_i
- Register update on each rising edge with rst_n=1, in priority order:
  - flush_i=1: load a bubble. ex_valid, ex_reg_write, ex_mem_read and ex_mem_write are 0; ex_rs/ex_rt/ex_rd are 0; data fields are don't-care and must be driven 0.
  - else stall_o=1: load a bubble (same as flush).
  - else: load all id_* fields; ex_valid = id_valid. When id_valid=0, controls are forced to 0.
- Latency: one cycle ID->EX. A load-use pair costs exactly one bubble. On the next cycle the load is in MEM/WB and the dependent instruction forwards via select 10.
- Forwarding selects are combinational from registered ex_rs/ex_rt and the live exmem/memwb inputs:
  - match_mem(r) = exmem_reg_write & exmem_rd!=0 & exmem_rd==r
  - match_wb(r) = memwb_reg_write & memwb_rd!=0 & memwb_rd==r
  - fwd_a_sel: 01 if match_mem(ex_rs); else 10 if match_wb(ex_rs); else 00. Never 11.
  - fwd_st_sel: same rule applied to ex_rt. Never 11.
  - fwd_b_sel: 11 if ex_alu_src (immediate); else equals fwd_st_sel.
  - EX/MEM has priority over MEM/WB when both match (newest value).
  - Register 0 never forwards.
  - ex_valid=0 forces all three selects to 00.
- Mux encoding consumed downstream: 00 = register data, 01 = EX/MEM ALU result, 10 = MEM/WB write-back data, 11 = ex_imm.
- stall_count increments on each rising edge where stall_o=1. It saturates at all-ones and does not wrap.
- Simultaneous flush and hazard: flush wins, stall_o=0, no count increment.
- Reset asserted mid-stall: the next edge clears everything. stall_o then drops because ex_valid=0.

Test Plan:
- Reset: hold rst_n=0 for 2 edges with random id_* inputs -> all ex_* = 0, selects = 00, stall_count = 0, stall_o = 0.
- Load-use: lw $8 into EX, then add $9,$8,$10 in ID -> stall_o=1 for exactly 1 cycle, bubble in EX (ex_valid=0), stall_count=1. Next cycle, with memwb_rd=8 and memwb_reg_write=1, add reaches EX with fwd_a_sel=10.
- Double forward: ex_rs=5, exmem_rd=5, memwb_rd=5, both write enables = 1 -> fwd_a_sel=01. Then set exmem_rd=0 -> fwd_a_sel=10. Then set rd=0 on both paths -> fwd_a_sel=00.
- Immediate/store: sw with ex_alu_src=1, ex_rt=7, exmem_rd=7 -> fwd_b_sel=11, fwd_st_sel=01.
- Flush versus hazard: load-use condition together with flush_i=1 -> stall_o=0, bubble loaded, stall_count unchanged.
- Saturation: preload the counter near max via CNT_W=4, then force 20 hazard cycles -> stall_count sticks at 4'hF.
